// File: rtl/nv_nvdla_cdp_dp_lut_idx_unit.sv
// -----------------------------------------------------------------------------
// nv_nvdla_cdp_dp_lut_idx_unit
//
// Purpose:
//   LUT index generator in front of the CDP interpolator. Each element is an
//   unsigned sum-of-squares. The block converts it into three results:
//     - a LUT segment index,
//     - a 17-bit fraction, where 0x10000 means 1.0,
//     - underflow/overflow flags.
//   It supports two addressing modes: linear (shifted offset from the start
//   value) and exponential (log2 of the offset). The datapath is a 2-stage
//   valid/ready pipeline.
//
//   Two saturating counters count the underflow and overflow outputs that the
//   downstream accepts.
//
// Ports:
//   nvdla_core_clk / nvdla_core_rstn : clock, asynchronous active-low reset
//   idx_in_vld / idx_in_rdy / idx_in_pd : input element stream (32-bit value)
//   cfg_lut_mode   : 0 = linear, 1 = exponential
//   cfg_lut_start  : LUT start value, subtracted from every element
//   cfg_lut_shift  : linear-mode right shift (0..31)
//   cfg_exp_offset : signed exponent offset (exponential mode only)
//   cfg_cnt_clr    : single-cycle pulse, clears both event counters
//   idx_out_vld / idx_out_rdy : output stream handshake
//   idx_out_index / idx_out_frac / idx_out_uflow / idx_out_oflow : results
//   uflow_cnt / oflow_cnt : saturating counts of accepted flagged outputs
//
// Handshake (valid/ready):
//   A transfer occurs on a rising clock edge where vld && rdy.
//   The producer holds vld and its payload stable until that transfer.
//   For each stage k, rdy_k = ~vld_k | rdy_(k+1).
//   A full stage therefore still accepts new data in the same cycle that its
//   own contents move on, which gives 1 element per cycle and a latency of
//   2 cycles.
// -----------------------------------------------------------------------------
module nv_nvdla_cdp_dp_lut_idx_unit #(
    parameter int LUT_IDX_W = 6,
    parameter int CNT_W     = 32
) (
    input  logic                 nvdla_core_clk,
    input  logic                 nvdla_core_rstn,
    input  logic                 idx_in_vld,
    output logic                 idx_in_rdy,
    input  logic [31:0]          idx_in_pd,
    input  logic                 cfg_lut_mode,
    input  logic [31:0]          cfg_lut_start,
    input  logic [4:0]           cfg_lut_shift,
    input  logic [7:0]           cfg_exp_offset,
    input  logic                 cfg_cnt_clr,
    output logic                 idx_out_vld,
    input  logic                 idx_out_rdy,
    output logic [LUT_IDX_W-1:0] idx_out_index,
    output logic [16:0]          idx_out_frac,
    output logic                 idx_out_uflow,
    output logic                 idx_out_oflow,
    output logic [CNT_W-1:0]     uflow_cnt,
    output logic [CNT_W-1:0]     oflow_cnt
);

    // ---------------------------------------------------------------- stage 0
    logic        vld_s0;
    logic        rdy_s0;
    logic        rdy_s1;
    logic        neg_s0;
    logic        zero_s0;
    logic [31:0] d_s0;
    logic [4:0]  p_s0;
    logic        mode_s0;
    logic [4:0]  shift_s0;
    logic [7:0]  off_s0;

    logic [32:0] diff;
    logic [4:0]  lead;

    assign rdy_s1     = ~idx_out_vld | idx_out_rdy;
    assign rdy_s0     = ~vld_s0 | rdy_s1;
    assign idx_in_rdy = rdy_s0;

    // 33-bit difference: bit 32 is the sign, because both operands are
    // zero-extended before the subtraction.
    assign diff = {1'b0, idx_in_pd} - {1'b0, cfg_lut_start};

    // Leading-one position of diff[31:0]. The value is only used when diff > 0.
    always_comb begin
        lead = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (diff[i]) begin
                lead = 5'(i);
            end
        end
    end

    // Config is captured together with the data, so a config change made
    // while elements are in flight leaves those elements unaffected.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            vld_s0   <= 1'b0;
            neg_s0   <= 1'b0;
            zero_s0  <= 1'b0;
            d_s0     <= 32'd0;
            p_s0     <= 5'd0;
            mode_s0  <= 1'b0;
            shift_s0 <= 5'd0;
            off_s0   <= 8'd0;
        end else begin
            if (rdy_s0) begin
                vld_s0 <= idx_in_vld;
            end
            if (idx_in_vld && rdy_s0) begin
                neg_s0   <= diff[32];
                zero_s0  <= (diff == 33'd0);
                d_s0     <= diff[31:0];
                p_s0     <= lead;
                mode_s0  <= cfg_lut_mode;
                shift_s0 <= cfg_lut_shift;
                off_s0   <= cfg_exp_offset;
            end
        end
    end

    // ---------------------------------------------------------------- stage 1
    logic [31:0]          q;
    logic signed [9:0]    e;
    logic [LUT_IDX_W-1:0] nx_index;
    logic [16:0]          nx_frac;
    logic                 nx_uflow;
    logic                 nx_oflow;

    assign q = d_s0 >> shift_s0;
    assign e = $signed({5'd0, p_s0}) - $signed({{2{off_s0[7]}}, off_s0});

    always_comb begin
        nx_index = '0;
        nx_frac  = 17'd0;
        nx_uflow = 1'b0;
        nx_oflow = 1'b0;
        if (!mode_s0) begin
            if (neg_s0) begin
                nx_uflow = 1'b1;
            end else if (|q[31:LUT_IDX_W]) begin
                nx_oflow = 1'b1;
                nx_index = '1;
                nx_frac  = 17'h10000;
            end else begin
                nx_index = q[LUT_IDX_W-1:0];
                // These are the bits shifted out below the shift point,
                // MSB-aligned and truncated to 16 bits.
                nx_frac  = {1'b0, 16'({d_s0, 16'h0000} >> shift_s0)};
            end
        end else begin
            if (neg_s0 || zero_s0 || e[9]) begin
                nx_uflow = 1'b1;
            end else if (|e[8:LUT_IDX_W]) begin
                nx_oflow = 1'b1;
                nx_index = '1;
                nx_frac  = 17'h10000;
            end else begin
                nx_index = e[LUT_IDX_W-1:0];
                // These are the bits below the leading one, MSB-aligned.
                nx_frac  = {1'b0, 16'({d_s0, 16'h0000} >> p_s0)};
            end
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            idx_out_vld   <= 1'b0;
            idx_out_index <= '0;
            idx_out_frac  <= 17'd0;
            idx_out_uflow <= 1'b0;
            idx_out_oflow <= 1'b0;
        end else begin
            if (rdy_s1) begin
                idx_out_vld <= vld_s0;
            end
            if (vld_s0 && rdy_s1) begin
                idx_out_index <= nx_index;
                idx_out_frac  <= nx_frac;
                idx_out_uflow <= nx_uflow;
                idx_out_oflow <= nx_oflow;
            end
        end
    end

    // --------------------------------------------------------------- counters
    logic out_hs;

    assign out_hs = idx_out_vld & idx_out_rdy;

    // A clear pulse takes priority over a coincident increment.
    // Both counters stop at all-ones instead of wrapping.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            uflow_cnt <= '0;
            oflow_cnt <= '0;
        end else if (cfg_cnt_clr) begin
            uflow_cnt <= '0;
            oflow_cnt <= '0;
        end else begin
            if (out_hs && idx_out_uflow && !(&uflow_cnt)) begin
                uflow_cnt <= uflow_cnt + CNT_W'(1);
            end
            if (out_hs && idx_out_oflow && !(&oflow_cnt)) begin
                oflow_cnt <= oflow_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_nv_nvdla_cdp_dp_lut_idx_unit.sv
// -----------------------------------------------------------------------------
// Testbench for nv_nvdla_cdp_dp_lut_idx_unit.
//
// The design is instantiated with CNT_W=4, so that counter saturation can be
// reached with a short burst of underflow elements.
//
// Expected results come from a reference function that works directly from
// the LUT addressing rules, using 64-bit integer arithmetic. The negedge
// monitor pushes one expected result for each accepted input and pops one for
// each accepted output. It also tracks both counters with a model.
// -----------------------------------------------------------------------------
module tb_nv_nvdla_cdp_dp_lut_idx_unit;

    localparam int IW = 6;
    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          in_vld;
    logic          in_rdy;
    logic [31:0]   in_pd;
    logic          cfg_mode;
    logic [31:0]   cfg_start;
    logic [4:0]    cfg_shift;
    logic [7:0]    cfg_off;
    logic          cfg_clr;
    logic          out_vld;
    logic          out_rdy;
    logic [IW-1:0] out_index;
    logic [16:0]   out_frac;
    logic          out_uflow;
    logic          out_oflow;
    logic [CW-1:0] ucnt;
    logic [CW-1:0] ocnt;

    nv_nvdla_cdp_dp_lut_idx_unit #(.LUT_IDX_W(IW), .CNT_W(CW)) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rst_n),
        .idx_in_vld      (in_vld),
        .idx_in_rdy      (in_rdy),
        .idx_in_pd       (in_pd),
        .cfg_lut_mode    (cfg_mode),
        .cfg_lut_start   (cfg_start),
        .cfg_lut_shift   (cfg_shift),
        .cfg_exp_offset  (cfg_off),
        .cfg_cnt_clr     (cfg_clr),
        .idx_out_vld     (out_vld),
        .idx_out_rdy     (out_rdy),
        .idx_out_index   (out_index),
        .idx_out_frac    (out_frac),
        .idx_out_uflow   (out_uflow),
        .idx_out_oflow   (out_oflow),
        .uflow_cnt       (ucnt),
        .oflow_cnt       (ocnt)
    );

    // ------------------------------------------------------- clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;
    logic rand_bp = 1'b0;

    // ------------------------------------------------------ reference model
    // Packed result layout: {uflow, oflow, index[5:0], frac[16:0]}.
    function automatic logic [24:0] model(input logic [31:0] x, input logic mode,
                                          input logic [31:0] start, input logic [4:0] shift,
                                          input logic [7:0] off);
        longint d, q, fr;
        int p, e;
        d = longint'(x) - longint'(start);
        if (!mode) begin
            if (d < 0) return {2'b10, 6'd0, 17'd0};
            q = d >>> shift;
            if (q >= 64) return {2'b01, 6'd63, 17'h10000};
            fr = ((d * 65536) >>> shift) % 65536;
            return {2'b00, 6'(q), 17'(fr)};
        end
        if (d <= 0) return {2'b10, 6'd0, 17'd0};
        p = 0;
        while ((d >>> (p + 1)) != 0) p++;
        e = p - int'($signed(off));
        if (e < 0) return {2'b10, 6'd0, 17'd0};
        if (e >= 64) return {2'b01, 6'd63, 17'h10000};
        fr = ((d * 65536) >>> p) % 65536;
        return {2'b00, 6'(e), 17'(fr)};
    endfunction

    // ------------------------------------------------------------ scoreboard
    logic [24:0]   exp_q[$];
    logic [CW-1:0] m_ucnt = '0;
    logic [CW-1:0] m_ocnt = '0;

    always @(negedge clk) begin
        logic [24:0] e;
        logic hs_u, hs_o;
        if (!rst_n) begin
            exp_q.delete();
            m_ucnt = '0;
            m_ocnt = '0;
        end else begin
            total++;
            assert (ucnt === m_ucnt) else begin
                bad++; $error("FAIL uflow_cnt got=%0d exp=%0d", ucnt, m_ucnt);
            end
            total++;
            assert (ocnt === m_ocnt) else begin
                bad++; $error("FAIL oflow_cnt got=%0d exp=%0d", ocnt, m_ocnt);
            end
            hs_u = 1'b0;
            hs_o = 1'b0;
            if (out_vld && out_rdy) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $error("FAIL unexpected_output got=%h exp=none",
                           {out_uflow, out_oflow, out_index, out_frac});
                end else begin
                    e = exp_q.pop_front();
                    assert ({out_uflow, out_oflow, out_index, out_frac} === e) else begin
                        bad++;
                        $error("FAIL output got u=%b o=%b idx=%0d frac=%h exp u=%b o=%b idx=%0d frac=%h",
                               out_uflow, out_oflow, out_index, out_frac,
                               e[24], e[23], e[22:17], e[16:0]);
                    end
                    hs_u = e[24];
                    hs_o = e[23];
                end
            end
            if (in_vld && in_rdy)
                exp_q.push_back(model(in_pd, cfg_mode, cfg_start, cfg_shift, cfg_off));
            if (cfg_clr) begin
                m_ucnt = '0;
                m_ocnt = '0;
            end else begin
                if (hs_u && m_ucnt != '1) m_ucnt++;
                if (hs_o && m_ocnt != '1) m_ocnt++;
            end
        end
    end

    // ---------------------------------------------------------- driver tasks
    // Every task starts and ends 1 time unit after a rising edge.
    task automatic send(input logic [31:0] x);
        logic ok;
        in_vld = 1'b1;
        in_pd  = x;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            ok = in_rdy;
            @(posedge clk); #1;
            if (rand_bp) out_rdy = ($urandom_range(0, 3) != 0);
            if (ok) begin
                in_vld = 1'b0;
                return;
            end
        end
        total++; bad++;
        $error("FAIL send_timeout got=stalled exp=accept");
        in_vld = 1'b0;
    endtask

    task automatic drain();
        out_rdy = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0 && !out_vld) return;
        end
        total++; bad++;
        $error("FAIL drain_timeout got=%0d exp=0", exp_q.size());
    endtask

    task automatic check_out(input string tag, input logic [24:0] exp);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_vld) begin
                total++;
                assert ({out_uflow, out_oflow, out_index, out_frac} === exp) else begin
                    bad++;
                    $error("FAIL %s got=%h exp=%h", tag,
                           {out_uflow, out_oflow, out_index, out_frac}, exp);
                end
                @(posedge clk); #1;
                return;
            end
        end
        total++; bad++;
        $error("FAIL %s_timeout got=no_valid exp=valid", tag);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++; $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_cfg(input logic mode, input logic [31:0] start,
                           input logic [4:0] shift, input logic [7:0] off);
        cfg_mode  = mode;
        cfg_start = start;
        cfg_shift = shift;
        cfg_off   = off;
    endtask

    // -------------------------------------------------------------- stimulus
    logic [31:0] bp_x[4];
    logic [31:0] rs;
    int acc;
    logic ok;

    initial begin
        rst_n = 1'b1;
        in_vld = 1'b0; in_pd = '0; cfg_clr = 1'b0; out_rdy = 1'b1;
        set_cfg(1'b0, 32'd0, 5'd0, 8'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_vld", 32'(out_vld), 0);
        chk("rst_out_data", 32'({out_uflow, out_oflow, out_index, out_frac}), 0);
        chk("rst_counters", 32'({ucnt, ocnt}), 0);
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Linear mode: check the 2-cycle latency and the result fields.
        set_cfg(1'b0, 32'd100, 5'd4, 8'd0);
        in_vld = 1'b1; in_pd = 32'd153;
        @(negedge clk); chk("t1_in_rdy", 32'(in_rdy), 1);
        @(posedge clk); #1 in_vld = 1'b0;
        @(negedge clk); chk("t1_lat1_vld", 32'(out_vld), 0);
        @(negedge clk); chk("t1_lat2_vld", 32'(out_vld), 1);
        chk("t1_result", 32'({out_uflow, out_oflow, out_index, out_frac}),
            32'({2'b00, 6'd3, 17'h05000}));
        drain();

        // Linear-mode underflow.
        send(32'd50);
        check_out("t2_uflow", {2'b10, 6'd0, 17'd0});
        drain(); @(negedge clk); chk("t2_ucnt", 32'(ucnt), 1);
        @(posedge clk); #1;

        // Linear-mode overflow, then the largest value that is not an overflow.
        set_cfg(1'b0, 32'd0, 5'd4, 8'd0);
        send(32'd1024);
        check_out("t3_oflow", {2'b01, 6'd63, 17'h10000});
        drain(); @(negedge clk); chk("t3_ocnt", 32'(ocnt), 1);
        @(posedge clk); #1;
        send(32'd1023);
        check_out("t3_top", {2'b00, 6'd63, 17'h0F000});
        drain();

        // Exponential mode: normal case, negative exponent, zero difference.
        set_cfg(1'b1, 32'd0, 5'd0, 8'd2);
        send(32'hC00); check_out("t4_exp", {2'b00, 6'd9, 17'h08000});
        send(32'd3);   check_out("t4_eneg", {2'b10, 6'd0, 17'd0});
        send(32'd0);   check_out("t4_zero", {2'b10, 6'd0, 17'd0});
        drain();

        // Back-pressure: 4 elements, output stalled for 6 cycles.
        set_cfg(1'b0, 32'd0, 5'd2, 8'd0);
        bp_x[0] = 32'h10; bp_x[1] = 32'h25; bp_x[2] = 32'h3A; bp_x[3] = 32'h41;
        out_rdy = 1'b0; acc = 0;
        in_vld = 1'b1; in_pd = bp_x[0];
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); ok = in_rdy;
            @(posedge clk); #1;
            if (ok) begin acc++; in_pd = bp_x[acc]; end
            if (c == 3) cfg_shift = 5'd3;
        end
        chk("t5_accepts", 32'(acc), 2);
        chk("t5_in_rdy_low", 32'(in_rdy), 0);
        out_rdy = 1'b1;
        for (int c = 0; c < 20 && acc < 4; c++) begin
            @(negedge clk);
            if (c < 2) chk("t5_consec_vld", 32'(out_vld), 1);
            ok = in_rdy;
            @(posedge clk); #1;
            if (ok) begin
                acc++;
                if (acc < 4) in_pd = bp_x[acc]; else in_vld = 1'b0;
            end
        end
        in_vld = 1'b0;
        drain();

        // A clear pulse in the same cycle as an underflow handshake.
        set_cfg(1'b0, 32'd100, 5'd0, 8'd0);
        out_rdy = 1'b0;
        send(32'd50);
        for (int i = 0; i < 20 && !out_vld; i++) @(negedge clk);
        @(posedge clk); #1 out_rdy = 1'b1; cfg_clr = 1'b1;
        @(posedge clk); #1 cfg_clr = 1'b0;
        @(negedge clk); chk("t6_clr_ucnt", 32'(ucnt), 0);
        @(posedge clk); #1;

        // Saturation of the 4-bit counter.
        for (int i = 0; i < 20; i++) send(32'd50);
        drain(); @(negedge clk); chk("t6_sat_ucnt", 32'(ucnt), 32'hF);
        @(posedge clk); #1;

        // Random configs, data and back-pressure.
        rand_bp = 1'b1;
        for (int n = 0; n < 300; n++) begin
            rs = $urandom;
            set_cfg(1'($urandom_range(0, 1)), rs, 5'($urandom_range(0, 31)),
                    8'($urandom_range(0, 48) - 8));
            case ($urandom_range(0, 3))
                0: send($urandom);
                1: send(rs + $urandom_range(0, 3000));
                2: send(rs - $urandom_range(0, 5));
                default: send(rs + ($urandom_range(0, 80) << cfg_shift));
            endcase
        end
        rand_bp = 1'b0;
        drain();

        // Reset while elements are still in the pipeline.
        set_cfg(1'b0, 32'd100, 5'd0, 8'd0);
        send(32'd50); send(32'd200); send(32'd60);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_rst_vld", 32'(out_vld), 0);
        chk("t6_rst_cnt", 32'({ucnt, ocnt}), 0);
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("t6_post_rst_vld", 32'(out_vld), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
